// File: rtl/mux_nx1_pipe_if.sv
// Handshake bundle for mux_nx1_pipe: upstream offer of {in_data, sel},
// downstream delivery of {out_data, out_sel, out_err}.
interface mux_nx1_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 16,
    parameter int SEL_W  = 4
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid
    );

    modport slave (
        input  in_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid
    );
endinterface

// File: rtl/mux_nx1_pipe.sv
// N-to-1 word selector with registered output and a two-entry skid buffer.
// Selection and range check happen at acceptance; outputs come from main.
module mux_nx1_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 16,
    parameter int SEL_W  = 4
) (
    input logic          clk,
    input logic          reset,
    mux_nx1_pipe_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d;
    logic             main_err_q, main_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic             skid_err_q, skid_err_d;

    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] pick_data;
    logic             pick_err;

    // Out-of-range selects store zero so nothing stale leaks downstream.
    always_comb begin
        pick_data = '0;
        pick_err  = (int'(bus.sel) >= NUM_IN);
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                pick_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = main_data_q;
    assign bus.out_sel   = main_sel_q;
    assign bus.out_err   = main_err_q;

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_data_d = pick_data;
                    main_sel_d  = bus.sel;
                    main_err_d  = pick_err;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    skid_data_d = pick_data;
                    skid_sel_d  = bus.sel;
                    skid_err_d  = pick_err;
                    state_d     = FULL;
                end else if (in_xfer && out_xfer) begin
                    main_data_d = pick_data;
                    main_sel_d  = bus.sel;
                    main_err_d  = pick_err;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                    main_err_d  = skid_err_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
        end
    end
endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: a 16-input and a 10-input instance share one
// stimulus stream and are checked against a queue model plus literals.
module tb_mux_nx1_pipe;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  sel;
    logic        out_ready;
    logic [31:0] words [16];
    logic [16*32-1:0] data16;

    int tests;
    int fails;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] word;
    } ent_t;

    ent_t q[$];

    mux_nx1_pipe_if #(.WIDTH(32), .NUM_IN(16), .SEL_W(4)) bus16 ();
    mux_nx1_pipe_if #(.WIDTH(32), .NUM_IN(10), .SEL_W(4)) bus10 ();

    mux_nx1_pipe #(.WIDTH(32), .NUM_IN(16), .SEL_W(4)) dut16 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus16.slave)
    );

    mux_nx1_pipe #(.WIDTH(32), .NUM_IN(10), .SEL_W(4)) dut10 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus10.slave)
    );

    always_comb begin
        data16 = '0;
        for (int i = 0; i < 16; i++) data16[i*32 +: 32] = words[i];
    end

    assign bus16.in_data   = data16;
    assign bus16.sel       = sel;
    assign bus16.in_valid  = in_valid;
    assign bus16.out_ready = out_ready;
    assign bus10.in_data   = data16[10*32-1:0];
    assign bus10.sel       = sel;
    assign bus10.in_valid  = in_valid;
    assign bus10.out_ready = out_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: FIFO of depth two, word chosen when the offer is taken.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else begin
            automatic bit ix = in_valid && (q.size() < 2);
            automatic bit ox = (q.size() > 0) && out_ready;
            if (ox) void'(q.pop_front());
            if (ix) q.push_back('{sel, words[sel]});
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("m16_valid", 64'(bus16.out_valid), 64'(q.size() != 0));
            chk("m16_ready", 64'(bus16.in_ready), 64'(q.size() < 2));
            chk("m10_valid", 64'(bus10.out_valid), 64'(q.size() != 0));
            chk("m10_ready", 64'(bus10.in_ready), 64'(q.size() < 2));
            if (q.size() != 0) begin
                automatic ent_t e = q[0];
                automatic bit er = (e.sel >= 4'd10);
                chk("m16_data", 64'(bus16.out_data), 64'(e.word));
                chk("m16_sel", 64'(bus16.out_sel), 64'(e.sel));
                chk("m16_err", 64'(bus16.out_err), 64'd0);
                chk("m10_data", 64'(bus10.out_data),
                    er ? 64'd0 : 64'(e.word));
                chk("m10_sel", 64'(bus10.out_sel), 64'(e.sel));
                chk("m10_err", 64'(bus10.out_err), 64'(er));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s,
                         input logic r);
        in_valid  = v;
        sel       = s;
        out_ready = r;
    endtask

    task automatic reset_words();
        for (int i = 0; i < 16; i++) words[i] = 32'hA000_0000 + i;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        reset_words();
        drive(1'b0, 4'd0, 1'b0);
        tick();
        tick();
        chk("rst_valid", 64'(bus16.out_valid), 64'd0);
        chk("rst_data", 64'(bus16.out_data), 64'd0);
        chk("rst_sel", 64'(bus16.out_sel), 64'd0);
        chk("rst_err", 64'(bus10.out_err), 64'd0);
        chk("rst_ready", 64'(bus16.in_ready), 64'd1);
        reset = 1'b0;

        // Streaming, one-cycle latency.
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 4'(k), 1'b1);
            tick();
            chk("stream_data", 64'(bus16.out_data), 64'(32'hA000_0000 + k));
            chk("stream_valid", 64'(bus16.out_valid), 64'd1);
        end
        drive(1'b0, 4'd0, 1'b1);
        tick();
        chk("stream_drain", 64'(bus16.out_valid), 64'd0);

        // Backpressure fills the skid.
        drive(1'b1, 4'd3, 1'b0);
        tick();
        chk("bp_ready1", 64'(bus16.in_ready), 64'd1);
        drive(1'b1, 4'd7, 1'b0);
        tick();
        chk("bp_ready2", 64'(bus16.in_ready), 64'd0);
        chk("bp_head", 64'(bus16.out_data), 64'h0A000_0003);
        drive(1'b0, 4'd0, 1'b1);
        tick();
        chk("bp_second", 64'(bus16.out_data), 64'h0A000_0007);
        chk("bp_ready3", 64'(bus16.in_ready), 64'd1);
        tick();
        chk("bp_empty", 64'(bus16.out_valid), 64'd0);

        // Simultaneous in and out while holding one word.
        drive(1'b1, 4'd2, 1'b0);
        tick();
        drive(1'b1, 4'd5, 1'b1);
        tick();
        chk("sim_data", 64'(bus16.out_data), 64'h0A000_0005);
        chk("sim_ready", 64'(bus16.in_ready), 64'd1);
        chk("sim_valid", 64'(bus16.out_valid), 64'd1);
        drive(1'b0, 4'd0, 1'b1);
        tick();

        // Range check on the 10-input instance.
        drive(1'b1, 4'd12, 1'b0);
        tick();
        chk("rng_err", 64'(bus10.out_err), 64'd1);
        chk("rng_data", 64'(bus10.out_data), 64'd0);
        chk("rng_sel", 64'(bus10.out_sel), 64'd12);
        chk("rng_16data", 64'(bus16.out_data), 64'h0A000_000C);
        drive(1'b1, 4'd9, 1'b1);
        tick();
        chk("rng_err9", 64'(bus10.out_err), 64'd0);
        chk("rng_data9", 64'(bus10.out_data), 64'h0A000_0009);
        drive(1'b0, 4'd0, 1'b1);
        tick();

        // Capture at acceptance; later in_data changes are ignored.
        words[4] = 32'h1234_5678;
        drive(1'b1, 4'd4, 1'b0);
        tick();
        drive(1'b0, 4'd0, 1'b0);
        words[4] = 32'hDEAD_BEEF;
        tick();
        chk("cap_data", 64'(bus16.out_data), 64'h1234_5678);
        tick();
        chk("cap_hold", 64'(bus16.out_data), 64'h1234_5678);
        drive(1'b0, 4'd0, 1'b1);
        tick();
        reset_words();

        // Reset mid-cycle with two words stored.
        drive(1'b1, 4'd1, 1'b0);
        tick();
        drive(1'b1, 4'd2, 1'b0);
        tick();
        drive(1'b1, 4'd6, 1'b0);
        chk("full_ready", 64'(bus16.in_ready), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(bus16.out_valid), 64'd0);
        chk("arst_data", 64'(bus16.out_data), 64'd0);
        chk("arst_ready", 64'(bus16.in_ready), 64'd1);
        tick();
        chk("arst_hold", 64'(bus16.out_valid), 64'd0);
        reset = 1'b0;
        drive(1'b0, 4'd0, 1'b1);
        tick();

        // Mixed valid/ready pattern against the model.
        for (int c = 0; c < 48; c++) begin
            automatic logic [47:0] rp = 48'hB2E5_6D19_C3A7;
            automatic logic [47:0] vp = 48'hF3B6_9E2D_75CB;
            out_ready = rp[c];
            if (!(in_valid && !bus16.in_ready)) begin
                in_valid = vp[c];
                sel      = 4'(c * 7);
            end
            words[c % 16] = 32'hC0DE_0000 + c;
            tick();
        end
        drive(1'b0, 4'd0, 1'b1);
        tick();
        tick();
        tick();
        chk("end_empty", 64'(bus16.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
